fp64_to_fp32_pipe: RTL and testbench
====================================

Name: fp64_to_fp32_pipe

Overview:
Streaming narrowing converter, IEEE-754 binary64 to binary32. It is the return-path companion to the fp32→fp64 widening converter, so fp32 results computed in the fp64 datapath can be written back to fp32 storage. Two-stage pipeline with valid/ready handshakes on both sides. Supports directed rounding and produces exception flags.

Parameters:
PIPE_STAGES, 2, number of register stages; only 2 is supported (elaboration error otherwise).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  64  binary64 operand
in_rm  in  2  rounding mode, sampled with in_data: 0=RNE, 1=RTZ, 2=RUP (+inf), 3=RDN (-inf)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  32  binary32 result
out_flags  out  5  {invalid, div0(always 0), overflow, underflow, inexact}

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: all stage-valid bits are 0, so out_valid=0. out_data=0 and out_flags=0. in_ready=1 once rst_n is deasserted.
- Handshake:
  - A beat transfers when valid&&ready on that side.
  - Stage k advances when it is empty, or when stage k+1 advances / output is accepted.
  - in_ready = !s1_valid || s1_advance. It is combinational from out_ready through at most 2 stages.
  - While out_valid=1 and out_ready=0, out_data and out_flags stay stable.
  - No beat is dropped or duplicated, and order is preserved.
- Latency: 2 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stage 1 (unpack/classify):
  - Classify the fp64 input into sNaN, qNaN, inf, zero, denorm, or normal.
  - Compute the target exponent t = E64 − 896 as a signed 12-bit value.
  - Form a 53-bit significand {hidden, mant64}.
  - If t ≤ 0, compute right-shift amount = 1 − t, saturated at 31.
  - Register class, sign, t, shift, significand and rm.
- Stage 2 (round/pack):
  - Align the significand: normal keeps bits [51:29]; a denormal target is right-shifted by the stage-1 amount.
  - Form G (guard), R (round) and S (OR of all lower bits, including shifted-out bits).
  - Round increment:
    - RNE: G&&(R||S||lsb)
    - RTZ: 0
    - RUP: !sign&&(G||R||S)
    - RDN: sign&&(G||R||S)
  - Mantissa carry-out increments the exponent. A denormal rounding up to 0x00800000 becomes the smallest normal.
- Overflow (t ≥ 255, before or after rounding):
  - RNE: ±inf.
  - RTZ: ±0x7F7FFFFF magnitude.
  - RUP: +inf if positive, −max finite if negative.
  - RDN: −inf if negative, +max finite if positive.
  - Flags: overflow=1, inexact=1.
- Underflow:
  - Tininess is detected before rounding (t ≤ 0 with a nonzero significand).
  - underflow=1 only if the result is also inexact.
  - Any fp64 denormal input is tiny and results in ±0 or ±0x00000001 depending on rm.
- NaN:
  - Output {sign, 0xFF, 1, mant64[50:29]}, always quiet.
  - invalid=1 for an sNaN input only.
- Inf maps to ±0x7F800000; zero maps to ±0. Neither raises a flag.
- inexact = G|R|S for any finite nonzero result.
- Reset mid-operation: all in-flight beats are discarded immediately. There is no partial output.

Decomposition:
- Shared package fp_pkg:
  - Rounding-mode localparams (RM_RNE/RTZ/RUP/RDN).
  - FP32/FP64 exponent/mantissa widths and biases (127, 1023).
  - Flag bit indices.
  - fp32 constants: QNAN, INF, MAX_FINITE.
- Classification reuses the existing fp_classify (#(64)) in stage 1.
- One natural sub-module: fp32_round_pack. It holds the combinational stage-2 logic: sign, t, aligned significand, rm in; packed word and flags out. fp32_round_pack is reusable by the fp32 arithmetic units.

Test Plan:
- 0x3FF0000000000000, RNE, out_ready=1 → 0x3F800000, flags 0, out_valid exactly 2 cycles after the accept.
- Tie: 0x3FF0000010000000 (1+2^-24) → RNE 0x3F800000, RUP 0x3F800001; inexact=1 in both.
- 0x7E37E43C8800759C (~1e300) → RNE 0x7F800000 with overflow+inexact; RTZ 0x7F7FFFFF; sign-flipped input with RUP → 0xFF7FFFFF.
- 0x7FF0000000000001 (sNaN) → 0x7FC00000, invalid=1. 0x36A0000000000000 (2^-149) → 0x00000001, flags 0. 0x0000000000000001 under RUP → 0x00000001 with underflow+inexact.
- Backpressure:
  - Stream 4 beats with out_ready=0: in_ready drops after 2 accepts and outputs hold stable.
  - Release out_ready: 4 results appear in order with no gaps.
  - Random valid/ready toggling over 10k beats matches the reference model.
- Assert rst_n low with 2 beats in flight → out_valid=0 asynchronously. After release, the first new beat emerges alone with a correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 widths, biases, rounding modes, flag indices and
// fp32 constants for the fp32/fp64 conversion datapath.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP64_EXP_W = 11;
    localparam int FP64_MAN_W = 52;
    localparam int FP32_BIAS  = 127;
    localparam int FP64_BIAS  = 1023;

    // Bit positions within the 5-bit {invalid, div0, overflow, underflow, inexact} vector
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    localparam logic [31:0] FP32_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF        = 32'h7F80_0000;
    localparam logic [31:0] FP32_MAX_FINITE = 32'h7F7F_FFFF;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    typedef struct packed {
        logic               sign;
        fp_class_e          cls;
        logic signed [11:0] t;
        logic [4:0]         sh;
        logic [52:0]        sig;
        logic [1:0]         rm;
    } cvt_s1_t;

endpackage

// File: rtl/fp64_to_fp32_pipe_if.sv
// fp64_to_fp32_pipe_if: input and output valid/ready streams of the narrowing converter.
interface fp64_to_fp32_pipe_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;

    modport master (
        output in_valid, in_data, in_rm, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_rm, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: rounds an aligned finite significand to binary32 and packs it,
// handling overflow saturation per rounding mode and tininess-before-rounding.
module fp32_round_pack
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic signed [11:0] t,
    input  logic [26:0]        sig,
    input  logic [1:0]         rm,
    output logic [31:0]        word,
    output logic [4:0]         flags
);

    logic        g, r, s, nx, inc, tiny, big, ovf, to_inf;
    logic [7:0]  e_field;
    logic [30:0] mag;

    assign {g, r, s} = sig[2:0];
    assign nx        = g | r | s;
    assign inc       = rm == RM_RNE ? g & (r | s | sig[3])
                     : rm == RM_RTZ ? 1'b0
                     : rm == RM_RUP ? !sign & nx
                     : sign & nx;
    assign tiny      = t <= 12'sd0;
    assign big       = t >= 12'sd255;
    // Hidden bit is clear for a denormal target, so its exponent field is zero and a
    // mantissa carry naturally promotes it to the smallest normal.
    assign e_field   = sig[26] && !big ? t[7:0] : 8'd0;
    assign mag       = {e_field, sig[25:3]} + 31'(inc);
    assign ovf       = big || &mag[30:23];
    assign to_inf    = rm == RM_RNE || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
    assign word      = {sign, ovf ? (to_inf ? FP32_INF[30:0] : FP32_MAX_FINITE[30:0]) : mag};

    always_comb begin
        flags          = '0;
        flags[FLAG_OF] = ovf;
        flags[FLAG_UF] = !ovf && tiny && nx;
        flags[FLAG_NX] = ovf || nx;
    end

endmodule

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-754 operand classifier for binary16/32/64.
module fp_classify
    import fp_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    output fp_class_e    cls
);

    localparam int EW = W == 64 ? FP64_EXP_W : W == 32 ? FP32_EXP_W : 5;
    localparam int MW = W - 1 - EW;

    logic [EW-1:0] e;
    logic [MW-1:0] m;

    assign e = x[W-2 -: EW];
    assign m = x[MW-1:0];

    always_comb
        cls = &e ? (m == '0 ? CLS_INF : m[MW-1] ? CLS_QNAN : CLS_SNAN)
            : |e ? CLS_NORMAL
            : m == '0 ? CLS_ZERO : CLS_DENORM;

endmodule

// File: rtl/fp64_to_fp32_pipe.sv
// fp64_to_fp32_pipe: two-stage streaming binary64 -> binary32 narrowing converter
// with directed rounding and IEEE exception flags.
module fp64_to_fp32_pipe
    import fp_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    fp64_to_fp32_pipe_if.slave bus
);

    if (PIPE_STAGES != 2) begin : g_bad_stages
        $error("fp64_to_fp32_pipe: only PIPE_STAGES=2 is supported");
    end

    localparam logic signed [11:0] T_OFF = 12'(FP64_BIAS - FP32_BIAS);

    fp_class_e          cls;
    cvt_s1_t            s1_d, s1_q;
    logic               s1_valid, s1_ready, s2_ready, is_nan, is_special;
    logic [10:0]        e64;
    logic signed [11:0] t;
    logic [83:0]        wide;
    logic [26:0]        aligned;
    logic [31:0]        rp_word, res;
    logic [4:0]         rp_flags, flg;

    assign s2_ready     = !bus.out_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    fp_classify #(.W(64)) u_classify (
        .x   (bus.in_data),
        .cls (cls)
    );

    assign e64 = bus.in_data[62:52];
    assign t   = $signed({1'b0, e64}) - T_OFF;

    always_comb begin
        s1_d.sign = bus.in_data[63];
        s1_d.cls  = cls;
        s1_d.t    = t;
        s1_d.sh   = t > 12'sd0 ? 5'd0 : t < -12'sd30 ? 5'd31 : 5'(12'sd1 - t);
        s1_d.sig  = {|e64, bus.in_data[51:0]};
        s1_d.rm   = bus.in_rm;
    end

    // Shifted-out bits land below the G/R positions and all fold into sticky.
    assign wide    = {s1_q.sig, 31'd0} >> s1_q.sh;
    assign aligned = {wide[83:58], |wide[57:0]};

    fp32_round_pack u_round_pack (
        .sign  (s1_q.sign),
        .t     (s1_q.t),
        .sig   (aligned),
        .rm    (s1_q.rm),
        .word  (rp_word),
        .flags (rp_flags)
    );

    assign is_nan     = s1_q.cls == CLS_QNAN || s1_q.cls == CLS_SNAN;
    assign is_special = s1_q.cls == CLS_INF || s1_q.cls == CLS_ZERO;
    assign res = is_nan ? {s1_q.sign, FP32_QNAN[30:22], s1_q.sig[50:29]}
               : s1_q.cls == CLS_INF ? {s1_q.sign, FP32_INF[30:0]}
               : s1_q.cls == CLS_ZERO ? {s1_q.sign, 31'd0}
               : rp_word;
    assign flg = is_nan ? {s1_q.cls == CLS_SNAN, 4'd0} : is_special ? 5'd0 : rp_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_q          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_flags <= '0;
        end else begin
            if (s1_ready) s1_valid <= bus.in_valid;
            if (bus.in_valid && s1_ready) s1_q <= s1_d;
            if (s2_ready) bus.out_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                bus.out_data  <= res;
                bus.out_flags <= flg;
            end
        end
    end

endmodule

// File: tb/tb_fp64_to_fp32_pipe.sv
// tb_fp64_to_fp32_pipe: directed-vector bench for the fp64 -> fp32 narrowing pipeline.
`timescale 1ns/1ps
module tb_fp64_to_fp32_pipe;

    localparam int NV = 24;
    localparam int NBEATS = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    logic [63:0] vd [NV] = '{
        64'h3FF0000000000000, 64'h3FF0000010000000, 64'h3FF0000010000000, 64'h7E37E43C8800759C,
        64'h7E37E43C8800759C, 64'hFE37E43C8800759C, 64'h7FF0000000000001, 64'h36A0000000000000,
        64'h0000000000000001, 64'h8000000000000001, 64'hFFF0000000000000, 64'h8000000000000000,
        64'h4000000000000000, 64'h7FF8000020000000, 64'h380FFFFFFFFFFFFF, 64'h47EFFFFFFFFFFFFF,
        64'h47EFFFFFFFFFFFFF, 64'h47EFFFFFE0000000, 64'h47F0000000000000, 64'h3FF0000030000000,
        64'hBFF0000000000001, 64'h7E37E43C8800759C, 64'hFE37E43C8800759C, 64'hFFF4000000000000
    };
    logic [1:0] vr [NV] = '{
        2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0,
        2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0,
        2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0
    };
    logic [31:0] vq [NV] = '{
        32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F800000,
        32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FC00000, 32'h00000001,
        32'h00000001, 32'h80000000, 32'hFF800000, 32'h80000000,
        32'h40000000, 32'h7FC00001, 32'h00800000, 32'h7F800000,
        32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800002,
        32'hBF800001, 32'h7F7FFFFF, 32'hFF800000, 32'hFFE00000
    };
    logic [4:0] vf [NV] = '{
        5'h00, 5'h01, 5'h01, 5'h05, 5'h05, 5'h05, 5'h10, 5'h00,
        5'h03, 5'h03, 5'h00, 5'h00, 5'h00, 5'h00, 5'h03, 5'h05,
        5'h01, 5'h00, 5'h05, 5'h01, 5'h01, 5'h05, 5'h05, 5'h10
    };

    fp64_to_fp32_pipe_if bus ();

    fp64_to_fp32_pipe #(.PIPE_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int k);
        bus.in_valid = k < 4;
        if (k < 4) begin
            bus.in_data = vd[k];
            bus.in_rm   = vr[k];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        tests++;
        if (bus.out_data !== 32'd0 || bus.out_flags !== 5'd0) begin
            fails++;
            $display("FAIL reset_out_data: got %h/%h want 00000000/00", bus.out_data, bus.out_flags);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_vectors;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vd[i];
            bus.in_rm    = vr[i];
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL vec_latency1[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL vec_latency2[%0d]: out_valid got %b want 1", i, bus.out_valid);
            end
            tests++;
            if ({bus.out_data, bus.out_flags} !== {vq[i], vf[i]}) begin
                fails++;
                $display("FAIL vec[%0d] in=%h rm=%0d: got %h/%h want %h/%h",
                         i, vd[i], vr[i], bus.out_data, bus.out_flags, vq[i], vf[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int k;
        logic acc;
        k = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(k);
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        tests++;
        if (k !== 2) begin
            fails++;
            $display("FAIL bp_accepts: got %0d want 2", k);
        end
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_flags} !== {vq[0], vf[0]}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b %h/%h want v=1 %h/%h",
                         c, bus.out_valid, bus.out_data, bus.out_flags, vq[0], vf[0]);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_flags} !== {vq[i], vf[i]}) begin
                fails++;
                $display("FAIL bp_order[%0d]: got v=%b %h/%h want v=1 %h/%h",
                         i, bus.out_valid, bus.out_data, bus.out_flags, vq[i], vf[i]);
            end
            bus.out_ready = 1'b1;
            drive(k);
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || k !== 4) begin
            fails++;
            $display("FAIL bp_drain: got out_valid=%b accepts=%0d want 0 and 4", bus.out_valid, k);
        end
    endtask

    task automatic test_random;
        int q[$];
        int sent, got, cyc, cur, idx;
        logic acc, fire;
        sent = 0;
        got  = 0;
        cyc  = 0;
        cur  = int'($urandom_range(NV - 1));
        while (got < NBEATS && cyc < 40000) begin
            bus.in_valid  = sent < NBEATS && $urandom_range(3) != 0;
            bus.in_data   = vd[cur];
            bus.in_rm     = vr[cur];
            bus.out_ready = $urandom_range(3) != 0;
            #1;
            acc  = bus.in_valid && bus.in_ready;
            fire = bus.out_valid && bus.out_ready;
            if (fire) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: got %h/%h with no beat outstanding", bus.out_data, bus.out_flags);
                end else begin
                    idx = q.pop_front();
                    if ({bus.out_data, bus.out_flags} !== {vq[idx], vf[idx]}) begin
                        fails++;
                        $display("FAIL rand_beat[%0d]: got %h/%h want %h/%h",
                                 got, bus.out_data, bus.out_flags, vq[idx], vf[idx]);
                    end
                end
                got++;
            end
            if (acc) begin
                q.push_back(cur);
                sent++;
                cur = int'($urandom_range(NV - 1));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests++;
        if (got !== NBEATS || q.size() != 0) begin
            fails++;
            $display("FAIL rand_count: got %0d results (%0d pending) want %0d", got, q.size(), NBEATS);
        end
    endtask

    task automatic test_reset_midflight;
        int cnt;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vd[i + 3];
            bus.in_rm    = vr[i + 3];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_inflight: got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_valid: got %b want 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = vd[19];
        bus.in_rm     = vr[19];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid === 1'b1) begin
                cnt++;
                tests++;
                if ({bus.out_data, bus.out_flags} !== {vq[19], vf[19]}) begin
                    fails++;
                    $display("FAIL rst_first_data: got %h/%h want %h/%h",
                             bus.out_data, bus.out_flags, vq[19], vf[19]);
                end
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (cnt !== 1) begin
            fails++;
            $display("FAIL rst_alone: got %0d valid results want 1", cnt);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_rm     = '0;
        bus.out_ready = 1'b0;
        test_reset;
        test_vectors;
        test_backpressure;
        test_random;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
